// File: rtl/sdram_frame_reader.sv
// rtl/sdram_frame_reader.sv - Avalon-MM frame read master feeding a credit-limited FWFT pixel FIFO.
module sdram_frame_reader #(
  parameter int ADDR_W      = 22,
  parameter int DATA_W      = 16,
  parameter int FRAME_WORDS = 76800,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic              clk_in_clk,
  input  logic              reset_reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] frame_base,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] m_address,
  output logic [1:0]        m_byteenable_n,
  output logic              m_chipselect,
  output logic              m_read_n,
  output logic              m_write_n,
  output logic [DATA_W-1:0] m_writedata,
  input  logic [DATA_W-1:0] m_readdata,
  input  logic              m_readdatavalid,
  input  logic              m_waitrequest,
  output logic [DATA_W-1:0] px_data,
  output logic              px_valid,
  input  logic              px_ready,
  output logic              px_last
);

  localparam int CNT_W  = $clog2(FRAME_WORDS + 1);
  localparam int PEND_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [CNT_W-1:0]  r_issued;
  logic [CNT_W-1:0]  r_out_cnt;
  logic [PEND_W-1:0] r_pending;
  logic [PEND_W-1:0] r_count;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic              r_done;
  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];

  logic [PEND_W:0]   w_credit;
  logic              w_req;
  logic              w_accept;
  logic              w_push;
  logic              w_pop;

  // Outstanding reads plus buffered words may never exceed the FIFO, so every return has a slot.
  assign w_credit = {1'b0, r_count} + {1'b0, r_pending};
  assign w_req    = (r_state == S_READ) && (r_issued < CNT_W'(FRAME_WORDS))
                    && (w_credit < (PEND_W + 1)'(FIFO_DEPTH));
  assign w_accept = w_req && !m_waitrequest;
  assign w_push   = m_readdatavalid && (r_state != S_IDLE);
  assign w_pop    = px_valid && px_ready;

  assign busy           = (r_state != S_IDLE);
  assign done           = r_done;
  assign m_address      = r_addr;
  assign m_byteenable_n = 2'b00;
  assign m_chipselect   = w_req;
  assign m_read_n       = !w_req;
  assign m_write_n      = 1'b1;
  assign m_writedata    = '0;
  assign px_valid       = (r_count != '0);
  assign px_data        = r_mem[r_rd_ptr];
  assign px_last        = px_valid && (r_out_cnt == CNT_W'(FRAME_WORDS - 1));

  always_ff @(posedge clk_in_clk) begin
    if (reset_reset) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_issued  <= '0;
      r_out_cnt <= '0;
      r_pending <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_addr    <= frame_base;
            r_issued  <= '0;
            r_out_cnt <= '0;
            r_pending <= '0;
            r_state   <= S_READ;
          end
        end
        S_READ: begin
          if (w_accept && (r_issued == CNT_W'(FRAME_WORDS - 1)))
            r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          if ((r_pending == '0) && (r_count == '0) && (r_out_cnt == CNT_W'(FRAME_WORDS))) begin
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
      if (w_accept) begin
        r_addr   <= r_addr + ADDR_W'(1);
        r_issued <= r_issued + CNT_W'(1);
      end
      if (w_accept && !w_push)
        r_pending <= r_pending + PEND_W'(1);
      else if (!w_accept && w_push)
        r_pending <= r_pending - PEND_W'(1);
      if (w_pop)
        r_out_cnt <= r_out_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_in_clk) begin
    if (reset_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push)
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_push && !w_pop)
        r_count <= r_count + PEND_W'(1);
      else if (!w_push && w_pop)
        r_count <= r_count - PEND_W'(1);
    end
  end

  always_ff @(posedge clk_in_clk) begin
    if (w_push)
      r_mem[r_wr_ptr] <= m_readdata;
  end

  always_ff @(posedge clk_in_clk) begin
    if (!reset_reset && w_push && !w_pop)
      assert (r_count != PEND_W'(FIFO_DEPTH));
  end

endmodule

// File: tb/tb_sdram_frame_reader.sv
// tb/tb_sdram_frame_reader.sv - directed bench with a 2-cycle-latency s1 slave model and pixel sink.
module tb_sdram_frame_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [21:0] frame_base = '0;
  logic        busy, done;
  logic [21:0] m_address;
  logic [1:0]  m_byteenable_n;
  logic        m_chipselect, m_read_n, m_write_n;
  logic [15:0] m_writedata;
  logic [15:0] m_readdata = '0;
  logic        m_readdatavalid = 1'b0;
  logic        m_waitrequest = 1'b0;
  logic [15:0] px_data;
  logic        px_valid;
  logic        px_ready = 1'b1;
  logic        px_last;

  int n_chk = 0;
  int n_pass = 0;

  logic [21:0] acc_addr [$];
  logic [15:0] pix_data [$];
  logic        pix_last [$];
  int          done_cnt = 0;
  int          outstanding = 0;
  int          max_out = 0;
  int          req_idx = 0;
  int          stall_idx = -1;
  int          stall_rem = 0;
  int          stall_cnt = 0;
  logic [21:0] stall_addr = '0;

  logic        p0_v = 1'b0, p1_v = 1'b0;
  logic [21:0] p0_a = '0, p1_a = '0;
  logic        present, acc;

  sdram_frame_reader #(
    .ADDR_W(22), .DATA_W(16), .FRAME_WORDS(8), .FIFO_DEPTH(4)
  ) dut (
    .clk_in_clk(clk), .reset_reset(rst), .start(start), .frame_base(frame_base),
    .busy(busy), .done(done), .m_address(m_address), .m_byteenable_n(m_byteenable_n),
    .m_chipselect(m_chipselect), .m_read_n(m_read_n), .m_write_n(m_write_n),
    .m_writedata(m_writedata), .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid),
    .m_waitrequest(m_waitrequest), .px_data(px_data), .px_valid(px_valid),
    .px_ready(px_ready), .px_last(px_last)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [21:0] a);
    return a[15:0] ^ 16'hC3A5 ^ {10'd0, a[21:16]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Slave and sink act on the falling edge for the following rising edge.
  always @(negedge clk) begin
    m_readdatavalid = p1_v;
    m_readdata      = mem_word(p1_a);
    p1_v = p0_v;
    p1_a = p0_a;
    present = !rst && m_chipselect && !m_read_n;
    if (present && req_idx == stall_idx && stall_rem > 0) begin
      m_waitrequest = 1'b1;
      stall_rem--;
      stall_cnt++;
      check("stall_addr", 32'(m_address), 32'(stall_addr));
      check("stall_read_n", 32'(m_read_n), 32'd0);
    end else begin
      m_waitrequest = 1'b0;
    end
    acc  = present && !m_waitrequest;
    p0_v = acc;
    p0_a = m_address;
    if (acc) begin
      acc_addr.push_back(m_address);
      req_idx++;
      outstanding++;
    end
    if (!rst && px_valid && px_ready) begin
      pix_data.push_back(px_data);
      pix_last.push_back(px_last);
      outstanding--;
    end
    if (outstanding > max_out) max_out = outstanding;
    if (done) done_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    acc_addr.delete();
    pix_data.delete();
    pix_last.delete();
    done_cnt = 0;
    outstanding = 0;
    max_out = 0;
    req_idx = 0;
    stall_cnt = 0;
  endtask

  task automatic start_frame(input logic [21:0] base);
    tick();
    frame_base = base;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!done && n < budget) begin
      tick();
      n++;
    end
    check("done_seen", 32'(done), 32'd1);
    check("busy_at_done", 32'(busy), 32'd0);
    tick();
    check("done_pulse", 32'(done), 32'd0);
  endtask

  task automatic check_frame(input logic [21:0] base);
    logic [21:0] e;
    check("n_accepted", 32'(acc_addr.size()), 32'd8);
    check("n_pixels", 32'(pix_data.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      e = base + 22'(i);
      if (i < acc_addr.size()) check("addr", 32'(acc_addr[i]), 32'(e));
      if (i < pix_data.size()) begin
        check("px_data", 32'(pix_data[i]), 32'(mem_word(e)));
        check("px_last", 32'(pix_last[i]), (i == 7) ? 32'd1 : 32'd0);
      end
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_cs"}, 32'(m_chipselect), 32'd0);
    check({tag, "_read_n"}, 32'(m_read_n), 32'd1);
    check({tag, "_addr"}, 32'(m_address), 32'd0);
    check({tag, "_px_valid"}, 32'(px_valid), 32'd0);
    check({tag, "_px_last"}, 32'(px_last), 32'd0);
  endtask

  initial begin
    repeat (2) tick();
    check_reset_values("rst");
    check("write_n", 32'(m_write_n), 32'd1);
    check("byteenable_n", 32'(m_byteenable_n), 32'd0);
    rst = 1'b0;

    clear_logs();
    start_frame(22'h000100);
    wait_done(200);
    check_frame(22'h000100);
    check("t1_done_cnt", 32'(done_cnt), 32'd1);

    clear_logs();
    px_ready = 1'b0;
    start_frame(22'h000100);
    repeat (20) tick();
    check("t2_accepted_stalled", 32'(acc_addr.size()), 32'd4);
    check("t2_cs_low", 32'(m_chipselect), 32'd0);
    check("t2_px_valid", 32'(px_valid), 32'd1);
    check("t2_head_data", 32'(px_data), 32'(mem_word(22'h000100)));
    px_ready = 1'b1;
    wait_done(200);
    check_frame(22'h000100);
    check("t2_max_fill", 32'(max_out), 32'd4);

    clear_logs();
    stall_idx = 2;
    stall_rem = 5;
    stall_addr = 22'h000042;
    start_frame(22'h000040);
    wait_done(200);
    check_frame(22'h000040);
    check("t3_stall_cycles", 32'(stall_cnt), 32'd5);
    stall_idx = -1;

    clear_logs();
    start_frame(22'h3FFFFE);
    wait_done(200);
    check_frame(22'h3FFFFE);

    clear_logs();
    start_frame(22'h000080);
    for (int i = 0; i < 20 && acc_addr.size() < 2; i++) tick();
    check("t5_two_pending", 32'(acc_addr.size()), 32'd2);
    rst = 1'b1;
    tick();
    check_reset_values("mid_rst");
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("t5_stale_dropped", 32'(px_valid), 32'd0);
      tick();
    end
    clear_logs();
    start_frame(22'h000080);
    wait_done(200);
    check_frame(22'h000080);

    clear_logs();
    start_frame(22'h000200);
    repeat (3) tick();
    frame_base = 22'h000300;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t6_still_busy", 32'(busy), 32'd1);
    wait_done(200);
    check_frame(22'h000200);
    repeat (5) tick();
    check("t6_one_done", 32'(done_cnt), 32'd1);
    check("t6_idle", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
